// File: rtl/mips_fetch_pkg.sv
// Shared encodings and default addresses for the MIPS fetch / PC sequencer.
package mips_fetch_defs;

  typedef enum logic [1:0] {
    CT_FALL   = 2'b00,
    CT_BRANCH = 2'b01,
    CT_JUMP   = 2'b10,
    CT_JR     = 2'b11
  } ctrl_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

  // Word-aligned, sign-extended branch displacement from an I-type immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_fetch_next_pc.sv
// Combinational next-PC select applied when decode retires the held instruction.
module mips_next_pc
  import mips_fetch_defs::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic [25:0] inst,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] pc4;

  assign pc4 = pc + 32'd4;

  // Exception outranks everything, including a misaligned jr.
  always_comb begin
    next_pc  = pc4;
    misalign = 1'b0;
    if (except) begin
      next_pc = EXC_VECTOR;
    end else begin
      case (ctrl_type_e'(control_type))
        CT_JR: begin
          if (jr_target[1:0] != 2'b00) begin
            next_pc  = EXC_VECTOR;
            misalign = 1'b1;
          end else begin
            next_pc = jr_target;
          end
        end
        CT_JUMP:   next_pc = {pc4[31:28], inst[25:0], 2'b00};
        CT_BRANCH: next_pc = pc4 + branch_offset(inst[15:0]);
        default:   next_pc = pc4;
      endcase
    end
  end

endmodule

// File: rtl/mips_fetch.sv
// Single-outstanding instruction fetch: imem req/ack on one side, decode
// valid/ready on the other, with PC redirect and retired-instruction count.
module mips_fetch
  import mips_fetch_defs::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  input  logic [1:0]  control_type,
  input  logic        except,
  input  logic [31:0] jr_target,
  output logic        addr_err,
  output logic [31:0] instret
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic         inst_valid_q, inst_valid_d;
  logic         addr_err_q, addr_err_d;
  logic [31:0]  instret_q, instret_d;

  logic [31:0]  next_pc;
  logic         misalign;

  mips_next_pc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc (
    .pc           (pc_q),
    .inst         (inst_q[25:0]),
    .control_type (control_type),
    .except       (except),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      instret_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      instret_q    <= instret_d;
    end
  end

  // Decoder inputs only matter on an accept in HOLD; ack only matters in REQ.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    addr_err_d   = 1'b0;
    instret_d    = instret_q;
    imem_req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          inst_d       = imem_rdata;
          pc_d         = fetch_pc_q;
          inst_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          inst_valid_d = 1'b0;
          instret_d    = instret_q + 32'd1;
          fetch_pc_d   = next_pc;
          addr_err_d   = misalign;
          state_d      = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_addr  = fetch_pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign addr_err   = addr_err_q;
  assign instret    = instret_q;

endmodule

// File: doc/mips_fetch.md
Name: mips_fetch

Overview:
- Instruction-fetch and PC sequencer: produces the instruction word whose opcode/funct fields the decoder consumes, and consumes the decoder's control_type/except back to select the next PC.
- Sits between the instruction memory (req/ack handshake) and decode/execute (valid/ready handshake).
- One instruction in flight; also counts retired instructions.

Parameters:
- RESET_PC, 32'h00400000, PC fetched first after reset.
- EXC_VECTOR, 32'h80000180, redirect target on except or misaligned jr.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  byte address of fetch; stable while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle; may arrive in the same cycle as imem_req.
- imem_rdata  in  32  instruction word.
- inst  out  32  held instruction to decode.
- inst_valid  out  1  inst/pc valid.
- inst_ready  in  1  decode/execute accepts (retires) inst this cycle.
- pc  out  32  address of inst.
- control_type  in  2  00 fallthrough, 01 branch taken, 10 j, 11 jr; sampled only on accept.
- except  in  1  decoder exception; sampled only on accept.
- jr_target  in  32  rs register value for jr.
- addr_err  out  1  one-cycle pulse: accepted jr had jr_target[1:0]!=0.
- instret  out  32  count of accepted instructions.

Behaviour:
- Reset (reset=0, async): state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, addr_err=0, instret=0. Reset mid-fetch abandons the request; an ack arriving during or after reset while not in REQ is ignored.
- FSM states: IDLE, REQ, HOLD.
- IDLE: imem_req=0; goes to REQ on the next clk edge (the first cycle after reset release).
- REQ:
  - imem_req=1, imem_addr=fetch_pc.
  - On imem_ack: inst<=imem_rdata, pc<=fetch_pc, inst_valid<=1, go to HOLD.
  - Without ack: stay, address unchanged.
- HOLD: inst_valid=1, imem_req=0. On inst_ready (accept):
  - inst_valid<=0; instret<=instret+1 (wraps mod 2^32); go to REQ.
  - fetch_pc<=next_pc, where pc4=pc+4, selected by priority:
    1. except=1 -> EXC_VECTOR.
    2. control_type=11 and jr_target[1:0]!=0 -> EXC_VECTOR; addr_err=1 for the cycle after accept.
    3. 11 -> jr_target.
    4. 10 -> {pc4[31:28], inst[25:0], 2'b00}.
    5. 01 -> pc4 + ({{14{inst[15]}}, inst[15:0], 2'b00}).
    6. 00 -> pc4.
- All PC arithmetic is 32-bit and wraps silently (pc=32'hFFFFFFFC fallthrough -> 0).
- Latency:
  - Accept at edge N -> imem_req high in cycle N+1.
  - Zero-wait ack -> inst_valid at N+2.
  - Each memory wait cycle adds one.
- control_type, except and jr_target are ignored outside HOLD&inst_ready.
- imem_ack outside REQ is ignored.
- inst, pc and inst_valid change only on the transitions above.

Decomposition:
- Package mips_fetch_defs: CT_FALL/CT_BRANCH/CT_JUMP/CT_JR encodings, state encodings, RESET_PC and EXC_VECTOR defaults.
- Sub-module mips_next_pc: combinational next-PC select (pc, inst, control_type, except, jr_target -> next_pc, misalign).
- The FSM, registers and counter stay in mips_fetch.

Test Plan:
- Reset release with zero-wait memory returning 32'h00000020 and inst_ready=1 -> imem_addr 00400000, 00400004, 00400008 on successive requests; instret increments by 1 per accept.
- Memory with 3 wait cycles -> imem_req and imem_addr held stable 3 extra cycles; inst_valid rises the cycle after ack.
- inst=32'h1000FFFF, pc=00400010, control_type=01 -> next imem_addr 00400010. With control_type=00 -> 00400014.
- j with inst[25:0]=26'h0100000, pc=00400000 -> imem_addr 00400000. jr with jr_target=00400100 -> 00400100. jr with jr_target=00400102 -> EXC_VECTOR and addr_err pulse.
- except=1 together with control_type=10 on accept -> EXC_VECTOR (except wins); inst_ready=0 held for 5 cycles -> inst and pc unchanged, no imem_req.
- Assert reset during REQ with a pending ack -> all outputs return to reset values immediately; after release, first imem_addr=RESET_PC and instret=0.
